pipe_stage_buf: RTL and testbench

Parametrised inter-stage pipeline buffer for the five-stage RISC-V core, the successor to the fixed single-entry stage registers between IF/ID/EX/MEM/WB. It carries a `DATA_W`-bit stage payload under the existing valid/allow_in handshake. It holds up to `DEPTH` entries in a circular buffer and adds a synchronous flush (branch redirect) and a hold input (load-use freeze). Instances sit between any two stage modules of `top`.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/pipe_buf_mem.sv | 34 +++
 rtl/pipe_stage_buf.sv | 116 +++++++++++
 tb/tb_pipe_stage_buf.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants for the five-stage core's inter-stage buffers.
//   Stage payload widths, used as DATA_W at each pipe_stage_buf instance,
//   plus a helper that sizes buffer pointers.
// Ports: none (package).
package pipeline_pkg;

  // Payload widths carried across each stage boundary.
  localparam int FS_DATA     = 64;   // pc + fetched instruction
  localparam int ID_DATA     = 160;  // decoded controls, operands, pc
  localparam int EX_DATA     = 106;  // alu result, store data, controls
  localparam int MEM_DATA    = 70;   // writeback value, rd, controls
  localparam int WB_DATA     = 38;   // final rd write
  localparam int BRANCH_DATA = 33;   // redirect flag + target

  localparam int BUF_DEPTH_MAX = 8;

  // Pointer width for a depth-entry buffer; a single entry still needs one bit
  // so the pointer nets are never zero-width.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// pipe_buf_mem: DEPTH x DATA_W register array for pipe_stage_buf.
//   One synchronous write port, one asynchronous read port; every entry
//   clears to zero on reset.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   we, waddr, wdata    write enable / address / data
//   raddr, rdata        combinational read address / data
module pipe_buf_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry circular buffer between two pipeline stages,
//   using the valid/allow_in handshake, with branch-redirect flush and
//   load-use hold.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   in_valid, in_data, in_allow_in  upstream side (in_allow_in is combinational)
//   out_valid, out_data             head entry, driven from flops
//   out_allow_in                    downstream accept
//   flush                           drop all entries and the same-cycle push
//   hold                            freeze the head; pushes still land if room
//   count                           occupancy
//   perf_stall_cnt                  stall cycle counter, only with
//                                   PIPE_STAGE_BUF_PERF_EN defined
module pipe_stage_buf
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_allow_in,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_allow_in,
  input  logic                         flush,
  input  logic                         hold,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [31:0]                  perf_stall_cnt
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, full;

  assign full        = (count_q == CNT_FULL);
  // A full buffer can still take a word when the head leaves this cycle.
  assign in_allow_in = ~full | (out_allow_in & ~hold);
  assign out_valid   = (count_q != '0);
  assign count       = count_q;

  assign push = in_valid & in_allow_in & ~flush;
  assign pop  = out_valid & out_allow_in & ~hold & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flush never writes storage: push already excludes it, so stale entries
  // simply sit behind the reset pointers.
  pipe_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0] stall_cnt_q;

  // A stall is a cycle where the head is valid but does not leave; flush
  // cycles are redirects, not stalls. Saturates rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !pop && !flush && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_allow_in = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;

  logic        allow2, valid2, allow3, valid3;
  logic [31:0] data2, data3;
  logic [1:0]  count2, count3;
  logic [31:0] perf2, perf3;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a bounded queue per instance plus a stall counter.
  logic [31:0] q2[$];
  logic [31:0] q3[$];
  logic [31:0] stall2 = '0;
  logic [31:0] stall3 = '0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_allow_in(allow2), .out_valid(valid2), .out_data(data2),
    .out_allow_in(out_allow_in), .flush(flush), .hold(hold), .count(count2)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .perf_stall_cnt(perf2)
`endif
  );

  pipe_stage_buf #(.DATA_W(32), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_allow_in(allow3), .out_valid(valid3), .out_data(data3),
    .out_allow_in(out_allow_in), .flush(flush), .hold(hold), .count(count3)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .perf_stall_cnt(perf3)
`endif
  );

`ifndef PIPE_STAGE_BUF_PERF_EN
  assign perf2 = '0;
  assign perf3 = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_one(input string tag, input int depth, input int sz,
                           input logic [31:0] head, input logic allow, input logic valid,
                           input logic [31:0] data, input logic [1:0] cnt);
    chk({tag, ".count"}, 64'(cnt), 64'(sz));
    chk({tag, ".bound"}, 64'(int'(cnt) <= depth), 64'd1);
    chk({tag, ".out_valid"}, 64'(valid), 64'(sz != 0));
    chk({tag, ".in_allow_in"}, 64'(allow), 64'((sz != depth) || (out_allow_in && !hold)));
    if (sz != 0) chk({tag, ".out_data"}, 64'(data), 64'(head));
  endtask

  task automatic check_all();
    check_one("d2", 2, q2.size(), (q2.size() != 0) ? q2[0] : 32'h0, allow2, valid2, data2, count2);
    check_one("d3", 3, q3.size(), (q3.size() != 0) ? q3[0] : 32'h0, allow3, valid3, data3, count3);
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("d2.perf", 64'(perf2), 64'(stall2));
    chk("d3.perf", 64'(perf3), 64'(stall3));
`endif
  endtask

  // One clock: drive at negedge, check, advance the model across the edge.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic oa,
                       input logic fl, input logic hd);
    bit pu2, po2, st2, pu3, po3, st3;
    in_valid = iv; in_data = d; out_allow_in = oa; flush = fl; hold = hd;
    #1;
    check_all();
    pu2 = iv && ((q2.size() != 2) || (oa && !hd)) && !fl;
    po2 = (q2.size() != 0) && oa && !hd && !fl;
    st2 = (q2.size() != 0) && !po2 && !fl;
    pu3 = iv && ((q3.size() != 3) || (oa && !hd)) && !fl;
    po3 = (q3.size() != 0) && oa && !hd && !fl;
    st3 = (q3.size() != 0) && !po3 && !fl;
    @(posedge clk);
    if (fl) q2.delete();
    else begin
      if (po2) void'(q2.pop_front());
      if (pu2) q2.push_back(d);
    end
    if (fl) q3.delete();
    else begin
      if (po3) void'(q3.pop_front());
      if (pu3) q3.push_back(d);
    end
    if (st2 && stall2 != 32'hFFFF_FFFF) stall2 = stall2 + 1;
    if (st3 && stall3 != 32'hFFFF_FFFF) stall3 = stall3 + 1;
    @(negedge clk);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, ".d2.out_valid"}, 64'(valid2), 64'd0);
    chk({tag, ".d2.out_data"}, 64'(data2), 64'd0);
    chk({tag, ".d2.count"}, 64'(count2), 64'd0);
    chk({tag, ".d2.in_allow_in"}, 64'(allow2), 64'd1);
    chk({tag, ".d3.out_valid"}, 64'(valid3), 64'd0);
    chk({tag, ".d3.out_data"}, 64'(data3), 64'd0);
    chk({tag, ".d3.count"}, 64'(count3), 64'd0);
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk({tag, ".d2.perf"}, 64'(perf2), 64'd0);
`endif
  endtask

  // Assert reset part-way through a cycle and check outputs before the next edge.
  task automatic reset_mid(input string tag);
    in_valid = 0; out_allow_in = 0; flush = 0; hold = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 reset_values(tag);
    q2.delete(); q3.delete();
    stall2 = '0; stall3 = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset held from time zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_values("rst");
    reset = 1'b1;

    // Pass-through latency.
    cycle(1, 32'hDEAD_0001, 1, 0, 0);
    chk("pass.valid", 64'(valid2), 64'd1);
    chk("pass.data", 64'(data2), 64'hDEAD_0001);
    cycle(0, 0, 1, 0, 0);

    // Fill and backpressure on the two-entry buffer.
    cycle(1, 32'h11, 0, 0, 0);
    cycle(1, 32'h22, 0, 0, 0);
    chk("fill.count", 64'(count2), 64'd2);
    #1 chk("fill.allow", 64'(allow2), 64'd0);
    cycle(1, 32'h33, 0, 0, 0);
    chk("fill.ignored.count", 64'(count2), 64'd2);
    chk("fill.head0", 64'(data2), 64'h11);
    cycle(0, 0, 1, 0, 0);
    chk("fill.head1", 64'(data2), 64'h22);
    cycle(0, 0, 1, 0, 0);
    chk("fill.drained", 64'(count2), 64'd0);

    // Three-entry buffer is now holding 0x33; fill it, then stream through full.
    cycle(1, 32'h44, 0, 0, 0);
    cycle(1, 32'h55, 0, 0, 0);
    chk("full3.count", 64'(count3), 64'd3);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'h100 + i, 1, 0, 0);
      chk("full3.steady", 64'(count3), 64'd3);
    end
    chk("full3.order", 64'(data3), 64'h107);
    repeat (3) cycle(0, 0, 1, 0, 0);

    // Flush drops stored entries and the same-cycle push.
    cycle(1, 32'hA, 0, 0, 0);
    cycle(1, 32'hB, 0, 0, 0);
    cycle(1, 32'hC, 0, 1, 0);
    chk("flush.count", 64'(count2), 64'd0);
    chk("flush.valid", 64'(valid2), 64'd0);
    chk("flush.count3", 64'(count3), 64'd0);
    repeat (3) cycle(0, 0, 1, 0, 0);

    // Hold freezes the head while a push still lands.
    cycle(1, 32'h55, 0, 0, 0);
    repeat (2) begin
      cycle(0, 0, 1, 0, 1);
      chk("hold.data", 64'(data2), 64'h55);
      chk("hold.count", 64'(count2), 64'd1);
    end
    cycle(1, 32'h66, 1, 0, 1);
    chk("hold.push.count", 64'(count2), 64'd2);
    chk("hold.push.head", 64'(data2), 64'h55);
    cycle(0, 0, 1, 0, 0);
    chk("hold.release", 64'(data2), 64'h66);
    cycle(0, 0, 1, 0, 0);

    // Stall counting from a clean start, then reset with data in flight.
    reset_mid("rst1");
    cycle(1, 32'h77, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 0);
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("perf.five", 64'(perf2), 64'd5);
`endif
    chk("perf.head", 64'(data2), 64'h77);
    reset_mid("rst2");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 6) == 0);
    end
    reset_mid("rst3");
    cycle(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
